mips_mem_arbiter: RTL and testbench

- Shares a single Avalon-style memory port with wait-request between the CPU instruction-fetch port and the CPU data port.
- Used by the bus variant of the CPU, which has no separate instruction and data memories.
- Serialises the two requesters with a small FSM and registers all bus outputs.
- Returns read data and a one-cycle ack to each requester; the CPU holds its pipeline (clk_enable low) until the ack.

---
 rtl/mips_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mips_mem_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// Shares one Avalon-style memory port (with wait-request) between the CPU fetch
// port and the CPU data port, with fetch anti-starvation and a stuck-bus timeout.
module mips_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [3:0]  bus_byteenable,
  output logic [31:0] bus_writedata,
  input  logic [31:0] bus_readdata,
  input  logic        bus_waitrequest,
  output logic        bus_err,
  output logic        protocol_err,
  output logic        stall
);
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wait_cnt;
  logic          d_req;
  logic          data_wins;
  logic          grant_i;

  assign d_req     = d_read | d_write;
  assign data_wins = d_req & ~(i_req & (starve_cnt == STARVE_MAX));
  assign grant_i   = (state == GRANT_I);
  assign stall     = (i_req | d_read | d_write) & ~(i_ack | d_ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      starve_cnt     <= '0;
      wait_cnt       <= '0;
      bus_address    <= '0;
      bus_read       <= 1'b0;
      bus_write      <= 1'b0;
      bus_byteenable <= '0;
      bus_writedata  <= '0;
      i_rdata        <= '0;
      d_rdata        <= '0;
      i_ack          <= 1'b0;
      d_ack          <= 1'b0;
      bus_err        <= 1'b0;
      protocol_err   <= 1'b0;
    end else begin
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      bus_err <= 1'b0;
      if (d_read && d_write) protocol_err <= 1'b1;

      case (state)
        IDLE: begin
          if (data_wins) begin
            // a simultaneous read+write is treated as a write
            bus_address    <= d_addr;
            bus_writedata  <= d_wdata;
            bus_byteenable <= d_byteenable;
            bus_write      <= d_write;
            bus_read       <= ~d_write;
            starve_cnt     <= i_req ? starve_cnt + 1'b1 : '0;
            state          <= GRANT_D;
          end else if (i_req) begin
            bus_address    <= i_addr;
            bus_byteenable <= 4'hF;
            bus_read       <= 1'b1;
            starve_cnt     <= '0;
            state          <= GRANT_I;
          end else begin
            starve_cnt <= '0;
          end
        end

        GRANT_I, GRANT_D: begin
          if (!bus_waitrequest || wait_cnt == WAIT_LAST) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            wait_cnt  <= '0;
            i_ack     <= grant_i;
            d_ack     <= ~grant_i;
            bus_err   <= bus_waitrequest;
            state     <= RESP;
            // an aborted transfer hands back zero instead of bus garbage
            if (bus_waitrequest) begin
              if (grant_i) i_rdata <= '0;
              else         d_rdata <= '0;
            end else if (grant_i) begin
              i_rdata <= bus_readdata;
            end else if (!bus_write) begin
              d_rdata <= bus_readdata;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Randomised bench for mips_mem_arbiter: a transaction-timing model predicts every
// cycle's outputs; directed scenarios pin the model with literal expectations.
module tb_mips_mem_arbiter;
  localparam int SL = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_byteenable = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_writedata;
  logic [31:0] bus_readdata = '0;
  logic        bus_waitrequest = 1'b0;
  logic        bus_err;
  logic        protocol_err;
  logic        stall;

  always #5 clk = ~clk;

  mips_mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_rdata(d_rdata), .d_ack(d_ack),
    .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
    .bus_byteenable(bus_byteenable), .bus_writedata(bus_writedata),
    .bus_readdata(bus_readdata), .bus_waitrequest(bus_waitrequest),
    .bus_err(bus_err), .protocol_err(protocol_err), .stall(stall)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ns = 1;  // first cycle the arbiter is idle and may sample

  // requester intent
  bit          i_pend = 0, d_pend = 0, d_rd = 0, d_wr = 0;
  logic [31:0] ia = '0, da = '0, dwd = '0;
  logic [3:0]  dbe = '0;
  bit          auto_i = 0, auto_d = 0;
  int          force_w = -1;
  bit          force_rdv_en = 0;
  logic [31:0] force_rdv = '0;

  // model of the transaction in flight: strobe cycles [m_g, m_g+m_n), ack at m_a
  int          m_g = -100, m_n = 0, m_a = -100, m_w = 0, starve = 0;
  bit          m_to = 0, m_who_d = 0, m_wr = 0, m_perr = 0, both_prev = 0;
  logic [31:0] m_addr = '0, m_wd = '0, m_rdv = '0, m_ir = '0, m_dr = '0;
  logic [3:0]  m_be = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic start_txn(input bit is_d);
    int r;
    m_g = cyc + 1;
    if (force_w >= 0) m_w = force_w;
    else begin
      r = int'($urandom_range(0, 9));
      m_w = (r < 5) ? 0 : (r < 8) ? r - 4 : r + 8;
    end
    m_to  = (m_w >= TO);
    m_n   = m_to ? TO : m_w + 1;
    m_a   = m_g + m_n;
    ns    = m_a + 1;
    m_rdv = force_rdv_en ? force_rdv : $urandom;
    m_who_d = is_d;
    if (is_d) begin
      m_wr = d_write; m_addr = d_addr; m_wd = d_wdata; m_be = d_byteenable;
    end else begin
      m_wr = 1'b0; m_addr = i_addr; m_wd = '0; m_be = 4'hF;
    end
  endtask

  task automatic model_reset();
    m_g = -100; m_n = 0; m_a = -100; starve = 0;
    m_perr = 0; both_prev = 0; m_ir = '0; m_dr = '0;
    ns = cyc + 1;
  endtask

  // One clock: check registered outputs, update requesters, drive inputs, predict.
  task automatic cycle();
    bit win, ia_e, da_e, dq;
    int r;
    @(posedge clk);
    #1;
    cyc++;
    if (both_prev) m_perr = 1;
    win  = (cyc >= m_g) && (cyc < m_g + m_n);
    ia_e = (cyc == m_a) && !m_who_d;
    da_e = (cyc == m_a) && m_who_d;
    if (ia_e) m_ir = m_to ? 32'h0 : m_rdv;
    if (da_e && (m_to || !m_wr)) m_dr = m_to ? 32'h0 : m_rdv;

    chk1("bus_read", bus_read, win && !m_wr);
    chk1("bus_write", bus_write, win && m_wr);
    if (win) begin
      chk("bus_address", bus_address, m_addr);
      chk("bus_byteenable", {28'h0, bus_byteenable}, {28'h0, m_be});
      if (m_wr) chk("bus_writedata", bus_writedata, m_wd);
    end
    chk1("i_ack", i_ack, ia_e);
    chk1("d_ack", d_ack, da_e);
    chk("i_rdata", i_rdata, m_ir);
    chk("d_rdata", d_rdata, m_dr);
    chk1("bus_err", bus_err, (cyc == m_a) && m_to);
    chk1("protocol_err", protocol_err, m_perr);

    if (ia_e) i_pend = 0;
    if (da_e) d_pend = 0;
    if (auto_i && !i_pend && $urandom_range(0, 2) == 0) begin
      i_pend = 1; ia = $urandom;
    end
    if (auto_d && !d_pend && $urandom_range(0, 2) == 0) begin
      r = int'($urandom_range(0, 15));
      d_pend = 1; d_wr = (r < 6); d_rd = (r == 0) || (r >= 6);
      da = $urandom; dwd = $urandom; dbe = 4'($urandom);
    end
    i_req = i_pend; i_addr = ia;
    d_read = d_pend && d_rd; d_write = d_pend && d_wr;
    d_addr = da; d_wdata = dwd; d_byteenable = dbe;
    both_prev = d_read && d_write;

    if (cyc >= ns) begin
      dq = d_read || d_write;
      if (dq && !(i_req && starve == SL)) begin
        start_txn(1'b1);
        starve = i_req ? ((starve < SL) ? starve + 1 : SL) : 0;
      end else if (i_req) begin
        start_txn(1'b0);
        starve = 0;
      end else begin
        starve = 0;
        ns = cyc + 1;
      end
    end

    win = (cyc >= m_g) && (cyc < m_g + m_n);
    if (win) begin
      bus_waitrequest = (cyc - m_g) < m_w;
      bus_readdata = m_rdv;
    end else begin
      bus_waitrequest = 1'($urandom_range(0, 1));
      bus_readdata = $urandom;
    end
    #1;
    chk1("stall", stall, (i_req || d_read || d_write) && !(ia_e || da_e));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcyc, dack, iack, rcnt, ecyc, nd;
    bit seen;

    repeat (3) @(posedge clk);
    #1;
    chk1("rst_bus_read", bus_read, 1'b0);
    chk1("rst_bus_write", bus_write, 1'b0);
    chk("rst_bus_address", bus_address, 32'h0);
    chk("rst_bus_writedata", bus_writedata, 32'h0);
    chk("rst_bus_byteenable", {28'h0, bus_byteenable}, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk1("rst_acks", i_ack | d_ack, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    chk1("rst_protocol_err", protocol_err, 1'b0);
    reset = 1'b0;
    cyc = 0;
    model_reset();

    // zero-wait fetch
    force_w = 0; force_rdv_en = 1; force_rdv = 32'h24020005;
    i_pend = 1; ia = 32'hBFC00000;
    cycle();
    chk1("fetch_stall_c0", stall, 1'b1);
    cycle();
    chk1("fetch_read_c1", bus_read, 1'b1);
    chk("fetch_addr_c1", bus_address, 32'hBFC00000);
    chk1("fetch_stall_c1", stall, 1'b1);
    cycle();
    chk1("fetch_ack_c2", i_ack, 1'b1);
    chk("fetch_rdata_c2", i_rdata, 32'h24020005);

    // simultaneous fetch and data write: data first
    i_pend = 1; ia = 32'h00400000;
    d_pend = 1; d_wr = 1; d_rd = 0; da = 32'h1000; dwd = 32'hDEADBEEF; dbe = 4'b0011;
    wcyc = -1; dack = -1; iack = -1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (bus_write && wcyc < 0) begin
        wcyc = k;
        chk("simul_byteenable", {28'h0, bus_byteenable}, 32'h3);
      end
      if (d_ack) dack = k;
      if (i_ack) iack = k;
    end
    chk("simul_write_cycle", wcyc, 1);
    chk("simul_dack_cycle", dack, 2);
    chk("simul_iack_cycle", iack, 5);

    // starvation: data reads re-asserted continuously while fetch waits
    i_pend = 1; ia = 32'h00400010;
    nd = 0; seen = 0;
    for (int k = 0; k < 60; k++) begin
      if (!d_pend) begin
        d_pend = 1; d_rd = 1; d_wr = 0; da = 32'h2000 + 32'(4 * k);
      end
      cycle();
      if (d_ack) nd++;
      if (i_ack) begin
        seen = 1;
        break;
      end
    end
    d_pend = 0;
    chk1("starve_iack_seen", seen, 1'b1);
    chk("starve_data_acks", nd, 4);
    repeat (3) cycle();

    // three wait states on a data read
    force_w = 3; force_rdv = 32'h12345678;
    d_pend = 1; d_rd = 1; d_wr = 0; da = 32'h2000;
    rcnt = 0; dack = -1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (bus_read) rcnt++;
      if (d_ack) begin
        dack = k;
        chk("wait_d_rdata", d_rdata, 32'h12345678);
      end
    end
    chk("wait_strobe_cycles", rcnt, 4);
    chk("wait_dack_cycle", dack, 5);

    // timeout: waitrequest stuck high
    force_w = 30; force_rdv = 32'hAAAA5555;
    d_pend = 1; d_rd = 1; d_wr = 0; da = 32'h3000;
    rcnt = 0; dack = -1; ecyc = -1;
    for (int k = 0; k < 14; k++) begin
      cycle();
      if (bus_read) rcnt++;
      if (bus_err) ecyc = k;
      if (d_ack) begin
        dack = k;
        chk("timeout_d_rdata", d_rdata, 32'h0);
      end
    end
    chk("timeout_strobe_cycles", rcnt, TO);
    chk("timeout_dack_cycle", dack, TO + 1);
    chk("timeout_err_cycle", ecyc, TO + 1);
    force_w = 0; force_rdv = 32'h8C820004;
    i_pend = 1; ia = 32'hBFC00004;
    iack = -1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (i_ack) begin
        iack = k;
        chk("after_timeout_i_rdata", i_rdata, 32'h8C820004);
      end
    end
    chk("after_timeout_iack_cycle", iack, 2);

    // d_read and d_write together: issued as a write, protocol_err sticks
    d_pend = 1; d_rd = 1; d_wr = 1; da = 32'h4000; dwd = 32'h0BADF00D; dbe = 4'hC;
    cycle();
    cycle();
    chk1("both_bus_write", bus_write, 1'b1);
    chk1("both_bus_read", bus_read, 1'b0);
    repeat (3) cycle();
    chk1("both_protocol_err", protocol_err, 1'b1);

    // randomised traffic
    force_w = -1; force_rdv_en = 0;
    auto_i = 1; auto_d = 1;
    repeat (900) cycle();
    auto_i = 0; auto_d = 0;
    repeat (40) cycle();

    // reset during a stalled data grant, with read and write both high
    force_w = 30;
    d_pend = 1; d_rd = 1; d_wr = 0; da = 32'h5000;
    repeat (3) cycle();
    chk1("pre_reset_strobe", bus_read, 1'b1);
    reset = 1'b1; d_read = 1'b1; d_write = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    chk1("mid_reset_bus_read", bus_read, 1'b0);
    chk1("mid_reset_bus_write", bus_write, 1'b0);
    chk1("mid_reset_d_ack", d_ack, 1'b0);
    chk1("mid_reset_protocol_err", protocol_err, 1'b0);
    reset = 1'b0;
    d_pend = 0; i_pend = 0;
    d_read = 1'b0; d_write = 1'b0; i_req = 1'b0;
    model_reset();
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (d_ack || i_ack) nd++;
    end
    chk("post_reset_acks", nd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
